// File: rtl/fetch_stage.sv
// fetch_stage: PC, req/ack imem port, 1-word hold buffer and IF/ID register.
// Define FETCH_PERF_CNT_EN for saturating stall/flush/drop counters.
module fetch_stage #(
  parameter int              PC_W      = 12,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [18:0]     NOP_INSTR = 19'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_writebar,
  input  logic            IF_ID_loadbar,
  input  logic            IF_ID_flush,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [18:0]     imem_rdata,
  output logic [18:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc1,
  output logic            if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     perf_stall_cnt,
  output logic [15:0]     perf_flush_cnt,
  output logic [15:0]     perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_IDLE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nx;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] r_daddr;
  logic [PC_W-1:0] w_daddr_nx;
  logic [PC_W-1:0] r_pc1;
  logic [18:0]     r_hold;
  logic [18:0]     w_hold_nx;
  logic [18:0]     r_instr;
  logic [18:0]     w_word;
  logic            r_drop;
  logic            w_drop_nx;
  logic            r_valid;
  logic            w_ld;
  logic            w_dropped;
  logic            w_can;
  logic            w_ack;

  // A dropped request keeps its old address until the ack returns
  assign imem_req    = !rst && (r_state == S_FETCH);
  assign imem_addr   = r_drop ? r_daddr : r_pc;
  assign w_ack       = imem_req && imem_ack;
  assign w_can       = !IF_ID_loadbar && !IF_ID_flush;
  assign w_pc_inc    = r_pc + 1'b1;
  assign if_id_instr = r_instr;
  assign if_id_pc1   = r_pc1;
  assign if_id_valid = r_valid;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_daddr_nx = r_daddr;
    w_hold_nx  = r_hold;
    w_drop_nx  = r_drop;
    w_ld       = 1'b0;
    w_word     = imem_rdata;
    w_dropped  = 1'b0;
    if (redirect) begin
      w_pc_nx    = redirect_pc;
      w_state_nx = S_FETCH;
      w_hold_nx  = NOP_INSTR;
      w_dropped  = w_ack;
      if (imem_req && !imem_ack) begin
        w_drop_nx = 1'b1;
        if (!r_drop) w_daddr_nx = r_pc;
      end else begin
        w_drop_nx = 1'b0;
      end
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            if (r_drop) begin
              w_drop_nx = 1'b0;
              w_dropped = 1'b1;
              if (pc_writebar) w_state_nx = S_IDLE;
            end else if (w_can) begin
              w_ld = 1'b1;
              if (pc_writebar) w_state_nx = S_IDLE;
              else             w_pc_nx    = w_pc_inc;
            end else begin
              w_hold_nx  = imem_rdata;
              w_state_nx = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_can) begin
            w_ld       = 1'b1;
            w_word     = r_hold;
            w_pc_nx    = w_pc_inc;
            w_state_nx = pc_writebar ? S_IDLE : S_FETCH;
          end
        end
        S_IDLE: begin
          if (!pc_writebar) w_state_nx = S_FETCH;
        end
        default: w_state_nx = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_daddr <= '0;
      r_hold  <= NOP_INSTR;
      r_drop  <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc1   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_daddr <= w_daddr_nx;
      r_hold  <= w_hold_nx;
      r_drop  <= w_drop_nx;
      // Decode consumed the entry with nothing new behind it: bubble
      if (IF_ID_flush || (!w_ld && !IF_ID_loadbar)) begin
        r_instr <= NOP_INSTR;
        r_pc1   <= '0;
        r_valid <= 1'b0;
      end else if (w_ld) begin
        r_instr <= w_word;
        r_pc1   <= w_pc_inc;
        r_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (IF_ID_loadbar && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (IF_ID_flush && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
      if (w_dropped && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
  assign perf_drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a random run checked against
// a program-order stream model held in a scoreboard queue.
module tb_fetch_stage;

  typedef struct packed {
    logic [18:0] instr;
    logic [11:0] pc1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_writebar = 1'b0;
  logic        IF_ID_loadbar = 1'b0;
  logic        IF_ID_flush = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_rdata;
  logic [18:0] if_id_instr;
  logic [11:0] if_id_pc1;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
  logic [15:0] perf_drop_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_dlv = 0;
  int lat_hi = 0;
  int lat_cnt = 0;
  logic hold_ack = 1'b0;
  logic sb_on = 1'b0;
  logic p_wait = 1'b0;
  logic [11:0] p_addr = '0;
  logic [11:0] tail = '0;
  exp_t exp_q[$];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_writebar   (pc_writebar),
    .IF_ID_loadbar (IF_ID_loadbar),
    .IF_ID_flush   (IF_ID_flush),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc1     (if_id_pc1),
    .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_drop_cnt (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] memf(input logic [11:0] a);
    return {7'b0, a} + 19'd1;
  endfunction

  // Instruction memory: mem[k] = k+1, random wait states
  assign imem_ack   = imem_req && !hold_ack && (lat_cnt == 0);
  assign imem_rdata = memf(imem_addr);

  always @(posedge clk) begin
    if (rst) lat_cnt <= 0;
    else if (imem_ack) lat_cnt <= int'($urandom_range(lat_hi, 0));
    else if (imem_req && lat_cnt > 0) lat_cnt <= lat_cnt - 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic refill(input int n);
    while (exp_q.size() < n) begin
      exp_q.push_back({memf(tail), tail + 12'd1});
      tail = tail + 12'd1;
    end
  endtask

  task automatic rebase(input logic [11:0] t);
    exp_q.delete();
    tail = t;
    refill(64);
  endtask

  // Monitor: request stability and in-order delivery to decode
  always @(negedge clk) begin
    if (!rst && p_wait) begin
      n_chk++;
      if (!imem_req || imem_addr !== p_addr) begin
        n_fail++;
        $display("FAIL req_hold: req=%0b addr=%0h expected req=1 addr=%0h",
                 imem_req, imem_addr, p_addr);
      end
    end
    p_wait = !rst && imem_req && !imem_ack;
    p_addr = imem_addr;
    if (sb_on && if_id_valid && !IF_ID_loadbar) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream: got instr=%0h with no expected entry",
                 if_id_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_dlv++;
        if (if_id_instr !== e.instr || if_id_pc1 !== e.pc1) begin
          n_fail++;
          $display("FAIL stream: got instr=%0h pc1=%0h expected instr=%0h pc1=%0h",
                   if_id_instr, if_id_pc1, e.instr, e.pc1);
        end
      end
    end
  end

  initial begin
    logic stall;
    logic dor;
    logic [11:0] tgt;
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", 32'(if_id_instr), 32'd0);
    chk("rst_pc1", 32'(if_id_pc1), 32'd0);
    rst = 1'b0;
    #1;
    chk("t1_req0", 32'(imem_req), 32'd1);
    chk("t1_addr0", 32'(imem_addr), 32'd0);
    step();
    chk("t1_instr1", 32'(if_id_instr), 32'd1);
    chk("t1_pc1", 32'(if_id_pc1), 32'd1);
    chk("t1_valid", 32'(if_id_valid), 32'd1);
    chk("t1_addr1", 32'(imem_addr), 32'd1);
    step();
    chk("t1_instr2", 32'(if_id_instr), 32'd2);
    step();
    chk("t1_instr3", 32'(if_id_instr), 32'd3);
    step();
    chk("t2_instr4", 32'(if_id_instr), 32'd4);
    IF_ID_loadbar = 1'b1;
    pc_writebar = 1'b1;
    step();
    chk("t2_hold_a", 32'(if_id_instr), 32'd4);
    chk("t2_noreq", 32'(imem_req), 32'd0);
    step();
    chk("t2_hold_b", 32'(if_id_instr), 32'd4);
    IF_ID_loadbar = 1'b0;
    pc_writebar = 1'b0;
    step();
    chk("t2_instr5", 32'(if_id_instr), 32'd5);
    chk("t2_pc1_5", 32'(if_id_pc1), 32'd5);
    chk("t2_addr5", 32'(imem_addr), 32'd5);
    step();
    chk("t2_instr6", 32'(if_id_instr), 32'd6);
    step();
    chk("t3_addr7", 32'(imem_addr), 32'd7);
    hold_ack = 1'b1;
    redirect = 1'b1;
    IF_ID_flush = 1'b1;
    redirect_pc = 12'h040;
    step();
    chk("t3_addr_keep_a", 32'(imem_addr), 32'd7);
    chk("t3_valid0", 32'(if_id_valid), 32'd0);
    redirect = 1'b0;
    IF_ID_flush = 1'b0;
    step();
    chk("t3_addr_keep_b", 32'(imem_addr), 32'd7);
    chk("t3_req", 32'(imem_req), 32'd1);
    hold_ack = 1'b0;
    step();
    chk("t3_addr40", 32'(imem_addr), 32'h040);
    chk("t3_dropped", 32'(if_id_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t3_perf_drop", 32'(perf_drop_cnt), 32'd1);
`endif
    step();
    chk("t3_instr41", 32'(if_id_instr), 32'h041);
    chk("t3_pc1_41", 32'(if_id_pc1), 32'h041);
    IF_ID_flush = 1'b1;
    IF_ID_loadbar = 1'b1;
    pc_writebar = 1'b1;
    step();
    chk("t4_nop", 32'(if_id_instr), 32'd0);
    chk("t4_valid0", 32'(if_id_valid), 32'd0);
    IF_ID_flush = 1'b0;
    IF_ID_loadbar = 1'b0;
    pc_writebar = 1'b0;
    step();
    chk("t4_held_word", 32'(if_id_instr), 32'h042);
    redirect = 1'b1;
    IF_ID_flush = 1'b1;
    redirect_pc = 12'hFFE;
    step();
    redirect = 1'b0;
    IF_ID_flush = 1'b0;
    chk("t5_addrFFE", 32'(imem_addr), 32'hFFE);
    step();
    chk("t5_pc1_FFF", 32'(if_id_pc1), 32'hFFF);
    step();
    chk("t5_wrap_addr", 32'(imem_addr), 32'd0);
    chk("t5_wrap_pc1", 32'(if_id_pc1), 32'd0);
    chk("t5_wrap_instr", 32'(if_id_instr), 32'h01000);
    hold_ack = 1'b1;
    step();
    chk("t6_wait_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_req_in_rst", 32'(imem_req), 32'd0);
    step();
    chk("t6_valid0", 32'(if_id_valid), 32'd0);
    rst = 1'b0;
    hold_ack = 1'b0;
    #1;
    chk("t6_restart_addr", 32'(imem_addr), 32'd0);
    step();
    chk("t6_instr1", 32'(if_id_instr), 32'd1);

    lat_hi = 3;
    tgt = 12'(int'($urandom_range(4095, 0)));
    redirect = 1'b1;
    IF_ID_flush = 1'b1;
    redirect_pc = tgt;
    step();
    redirect = 1'b0;
    IF_ID_flush = 1'b0;
    rebase(tgt);
    sb_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(3, 0) == 0);
      dor = ($urandom_range(24, 0) == 0);
      if ($urandom_range(3, 0) == 0)
        tgt = 12'hFFC + 12'(int'($urandom_range(3, 0)));
      else
        tgt = 12'(int'($urandom_range(4095, 0)));
      pc_writebar = stall;
      IF_ID_loadbar = stall;
      redirect = dor;
      IF_ID_flush = dor;
      redirect_pc = tgt;
      step();
      if (dor) rebase(tgt);
      else if (exp_q.size() < 32) refill(64);
    end
    pc_writebar = 1'b0;
    IF_ID_loadbar = 1'b0;
    redirect = 1'b0;
    IF_ID_flush = 1'b0;
    repeat (10) step();
    sb_on = 1'b0;
    chk("progress", 32'(n_dlv >= 300), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
